// File: rtl/mc_request_queue.sv
// mc_request_queue: 16-entry aging request queue with a score-selected registered issue port.
// Define RQ_ROW_HIT_EN to build the open-row table that drives the row-hit status bit.
module mc_request_queue (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_class,
   input  logic [2:0]   req_bank,
   input  logic [13:0]  req_row,
   input  logic [9:0]   req_col,
   output logic [15:0]  sched_valid,
   output logic [95:0]  sched_age,
   output logic [47:0]  sched_unscheduled,
   input  logic [127:0] sched_score,
   output logic         issue_valid,
   input  logic         issue_ready,
   output logic [3:0]   issue_idx,
   output logic [1:0]   issue_class,
   output logic [2:0]   issue_bank,
   output logic [13:0]  issue_row,
   output logic [9:0]   issue_col,
   output logic [4:0]   occupancy
);
   logic [15:0] valid, inflight, eligible, hit;
   logic [5:0]  age [16];
   logic [1:0]  cls [16];
   logic [2:0]  bank [16];
   logic [13:0] row [16];
   logic [9:0]  col [16];
   logic [3:0]  alloc_idx, win;
   logic [7:0]  best;
   logic        accept, hs, load;

   assign req_ready   = |(~valid);
   assign accept      = req_valid & req_ready;
   assign eligible    = valid & ~inflight;
   assign hs          = issue_valid & issue_ready;
   assign load        = |eligible & (~issue_valid | hs);
   assign sched_valid = eligible;

   always_comb begin
      alloc_idx = '0;
      for (int i = 15; i >= 0; i--) if (!valid[i]) alloc_idx = 4'(i);
   end

   // scanning downward with >= leaves the lowest index holding the maximum score
   always_comb begin
      win  = '0;
      best = '0;
      for (int i = 15; i >= 0; i--)
         if (eligible[i] && sched_score[8*i +: 8] >= best) begin
            win  = 4'(i);
            best = sched_score[8*i +: 8];
         end
   end

`ifdef RQ_ROW_HIT_EN
   logic [7:0]  row_open;
   logic [13:0] open_row [8];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         row_open <= '0;
         for (int b = 0; b < 8; b++) open_row[b] <= '0;
      end else if (hs) begin
         row_open[issue_bank] <= 1'b1;
         open_row[issue_bank] <= issue_row;
      end
   always_comb begin
      hit = '0;
      for (int i = 0; i < 16; i++) hit[i] = row_open[bank[i]] && open_row[bank[i]] == row[i];
   end
`else
   assign hit = '0;
`endif

   always_comb begin
      sched_age         = '0;
      sched_unscheduled = '0;
      for (int i = 0; i < 16; i++) begin
         sched_age[6*i +: 6]         = age[i];
         sched_unscheduled[3*i +: 3] = {cls[i], hit[i]};
      end
   end

   // an allocated slot is free pre-edge, so it never collides with the freed or loaded entry
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid    <= '0;
         inflight <= '0;
         for (int i = 0; i < 16; i++) begin
            age[i]  <= '0;
            cls[i]  <= '0;
            bank[i] <= '0;
            row[i]  <= '0;
            col[i]  <= '0;
         end
      end else
         for (int i = 0; i < 16; i++)
            if (accept && alloc_idx == 4'(i)) begin
               valid[i]    <= 1'b1;
               inflight[i] <= 1'b0;
               age[i]      <= '0;
               cls[i]      <= req_class;
               bank[i]     <= req_bank;
               row[i]      <= req_row;
               col[i]      <= req_col;
            end else if (hs && issue_idx == 4'(i)) begin
               valid[i]    <= 1'b0;
               inflight[i] <= 1'b0;
            end else begin
               if (load && win == 4'(i)) inflight[i] <= 1'b1;
               if (eligible[i] && age[i] != 6'd63) age[i] <= age[i] + 6'd1;
            end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_idx   <= '0;
         issue_class <= '0;
         issue_bank  <= '0;
         issue_row   <= '0;
         issue_col   <= '0;
         occupancy   <= '0;
      end else begin
         occupancy <= occupancy + 5'(accept) - 5'(hs);
         if (load) begin
            issue_valid <= 1'b1;
            issue_idx   <= win;
            issue_class <= cls[win];
            issue_bank  <= bank[win];
            issue_row   <= row[win];
            issue_col   <= col[win];
         end else if (hs)
            issue_valid <= 1'b0;
      end
endmodule

// File: tb/tb_mc_request_queue.sv
// tb_mc_request_queue: scoreboard bench for mc_request_queue.
// Row-hit expectations follow RQ_ROW_HIT_EN when it is defined for the build.
module tb_mc_request_queue;
`ifdef RQ_ROW_HIT_EN
   localparam logic RH = 1'b1;
`else
   localparam logic RH = 1'b0;
`endif
   typedef struct { logic [3:0] idx; logic [28:0] data; } exp_t;

   logic         clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, issue_ready = 1'b0;
   logic         req_ready, issue_valid;
   logic [1:0]   req_class = '0, issue_class;
   logic [2:0]   req_bank = '0, issue_bank;
   logic [13:0]  req_row = '0, issue_row;
   logic [9:0]   req_col = '0, issue_col;
   logic [15:0]  sched_valid;
   logic [95:0]  sched_age;
   logic [47:0]  sched_unscheduled;
   logic [127:0] sched_score = '0;
   logic [3:0]   issue_idx;
   logic [4:0]   occupancy;

   exp_t        sb [$];
   logic [15:0] m_valid = '0;
   int          n_chk = 0, n_pass = 0, mon_f, cyc;

   always #5 clk = ~clk;

   mc_request_queue dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
      .sched_valid(sched_valid), .sched_age(sched_age), .sched_unscheduled(sched_unscheduled),
      .sched_score(sched_score), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_idx(issue_idx), .issue_class(issue_class), .issue_bank(issue_bank),
      .issue_row(issue_row), .issue_col(issue_col), .occupancy(occupancy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] c, input logic [2:0] b, input logic [13:0] r, input logic [9:0] co);
      logic [3:0] id = '0;
      for (int i = 15; i >= 0; i--) if (!m_valid[i]) id = 4'(i);
      m_valid[id] = 1'b1;
      sb.push_back('{id, {c, b, r, co}});
   endtask

   task automatic send(input logic [1:0] c, input logic [2:0] b, input logic [13:0] r, input logic [9:0] co);
      req_valid = 1'b1;
      req_class = c;
      req_bank  = b;
      req_row   = r;
      req_col   = co;
      for (int k = 0; k < 50 && !req_ready; k++) tick();
      check("send_ready", req_ready, 1);
      if (req_ready) begin
         push_exp(c, b, r, co);
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic drain();
      issue_ready = 1'b1;
      for (int k = 0; k < 40 && occupancy != 0; k++) tick();
      issue_ready = 1'b0;
      check("drain_occ", occupancy, 0);
      check("drain_sb", sb.size(), 0);
   endtask

   always @(negedge clk)
      if (rst_n && issue_valid && issue_ready) begin
         mon_f = -1;
         foreach (sb[j]) if (mon_f < 0 && sb[j].idx == issue_idx) mon_f = j;
         check("sb_idx_known", 32'(mon_f >= 0), 1);
         if (mon_f >= 0) begin
            check("sb_payload", {issue_class, issue_bank, issue_row, issue_col}, sb[mon_f].data);
            m_valid[sb[mon_f].idx] = 1'b0;
            sb.delete(mon_f);
         end
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      check("rst_req_ready", req_ready, 1);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_sched_valid", sched_valid, 0);

      issue_ready = 1'b1;
      send(2'b10, 3'd3, 14'h0055, 10'h012);
      check("single_occ", occupancy, 1);
      check("single_sched_valid", sched_valid, 16'h0001);
      check("single_not_yet", issue_valid, 0);
      tick();
      check("single_issue_valid", issue_valid, 1);
      check("single_idx", issue_idx, 0);
      check("single_class", issue_class, 2'b10);
      check("single_bank", issue_bank, 3);
      check("single_row", issue_row, 14'h0055);
      check("single_col", issue_col, 10'h012);
      check("single_inflight", sched_valid, 0);
      tick();
      check("single_done_valid", issue_valid, 0);
      check("single_done_occ", occupancy, 0);
      issue_ready = 1'b0;

      for (int i = 0; i < 16; i++) send(2'(i), 3'(i), 14'h0200 + 14'(i), 10'(i));
      check("full_ready", req_ready, 0);
      check("full_occ", occupancy, 16);
      check("full_issue_idx", issue_idx, 0);
      check("full_sched_valid", sched_valid, 16'hfffe);
      req_valid = 1'b1;
      req_class = 2'b11;
      req_bank  = 3'd5;
      req_row   = 14'h3abc;
      req_col   = 10'h2aa;
      repeat (2) tick();
      check("full_held_ready", req_ready, 0);
      check("full_held_occ", occupancy, 16);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("full_freed_ready", req_ready, 1);
      check("full_next_idx", issue_idx, 1);
      push_exp(2'b11, 3'd5, 14'h3abc, 10'h2aa);
      tick();
      req_valid = 1'b0;
      check("full_refill_occ", occupancy, 16);
      check("full_refill_valid", sched_valid, 16'hfffd);
      issue_ready = 1'b1;
      cyc = 0;
      while (occupancy != 0 && cyc < 40) begin
         tick();
         cyc++;
      end
      issue_ready = 1'b0;
      check("full_drain_cycles", cyc, 16);
      check("full_drain_sb", sb.size(), 0);

      send(2'b01, 3'd6, 14'h0010, 10'h001);
      send(2'b00, 3'd6, 14'h0011, 10'h002);
      check("age_start", sched_age[11:6], 0);
      repeat (40) tick();
      check("age_40", sched_age[11:6], 40);
      check("age_valid", sched_valid, 16'h0002);
      repeat (30) tick();
      check("age_sat", sched_age[11:6], 63);
      drain();

      sched_score[8*2 +: 8] = 8'h10;
      sched_score[8*5 +: 8] = 8'h10;
      for (int i = 0; i < 6; i++) send(2'b10, 3'd7, 14'h0300 + 14'(i), 10'(i));
      check("tie_first", issue_idx, 0);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("tie_winner", issue_idx, 2);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("tie_hold_idx", issue_idx, 2);
         check("tie_hold_valid", issue_valid, 1);
         check("tie_hold_row", issue_row, 14'h0302);
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("tie_second", issue_idx, 5);
      sched_score = '0;
      drain();

      send(2'b10, 3'd1, 14'h0100, 10'h000);
      send(2'b10, 3'd1, 14'h0100, 10'h001);
      send(2'b01, 3'd1, 14'h0101, 10'h002);
      send(2'b11, 3'd1, 14'h0100, 10'h003);
      check("rowhit_before", sched_unscheduled[9], 0);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("rowhit_loaded", issue_idx, 1);
      check("rowhit_same", sched_unscheduled[9], RH);
      check("rowhit_diff", sched_unscheduled[6], 0);
      check("rowhit_class", sched_unscheduled[11:10], 2'b11);

      sb.delete();
      m_valid = '0;
      rst_n = 1'b0;
      #2;
      check("midrst_issue_valid", issue_valid, 0);
      check("midrst_occ", occupancy, 0);
      check("midrst_ready", req_ready, 1);
      repeat (2) tick();
      rst_n = 1'b1;
      check("postrst_sched_valid", sched_valid, 0);
      check("postrst_age", 32'(|sched_age), 0);
      check("postrst_idx", issue_idx, 0);
      check("postrst_row", issue_row, 0);
      send(2'b10, 3'd1, 14'h0100, 10'h004);
      send(2'b10, 3'd1, 14'h0100, 10'h005);
      check("postrst_row_closed", sched_unscheduled[3], 0);
      check("postrst_issue_idx", issue_idx, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
